// File: rtl/wt_cache_pkg.sv
// Shared request/return types for the write-through cache memory path.
// TID_W sets the per-source tid width that the arbiter widens by one source bit.
package wt_cache_pkg;

  localparam int unsigned TID_W = 2;

  typedef enum logic [1:0] {
    MEM_RTYPE_LOAD  = 2'd0,
    MEM_RTYPE_STORE = 2'd1,
    MEM_RTYPE_AMO   = 2'd2,
    MEM_RTYPE_IFILL = 2'd3
  } mem_rtype_e;

  typedef struct packed {
    mem_rtype_e       rtype;
    logic [TID_W-1:0] tid;
    logic [63:0]      paddr;
    logic [2:0]       size;
    logic [63:0]      data;
    logic             nc;
  } mem_src_req_t;

  typedef struct packed {
    mem_rtype_e     rtype;
    logic [TID_W:0] tid;
    logic [63:0]    paddr;
    logic [2:0]     size;
    logic [63:0]    data;
    logic           nc;
  } mem_req_t;

  typedef struct packed {
    mem_rtype_e     rtype;
    logic [TID_W:0] tid;
    logic [127:0]   data;
  } mem_rtrn_t;

  typedef struct packed {
    mem_rtype_e       rtype;
    logic [TID_W-1:0] tid;
    logic [127:0]     data;
  } mem_src_rtrn_t;

  // Prefix the source bit onto the tid; every other field passes through.
  function automatic mem_req_t tag_req(input mem_src_req_t r, input logic src);
    mem_req_t o;
    o.rtype = r.rtype;
    o.tid   = {src, r.tid};
    o.paddr = r.paddr;
    o.size  = r.size;
    o.data  = r.data;
    o.nc    = r.nc;
    return o;
  endfunction

  function automatic mem_src_rtrn_t strip_rtrn(input mem_rtrn_t r);
    mem_src_rtrn_t o;
    o.rtype = r.rtype;
    o.tid   = r.tid[TID_W-1:0];
    o.data  = r.data;
    return o;
  endfunction

endpackage

// File: rtl/wt_mem_arbiter_if.sv
// Memory-adapter request channel: valid/ready handshake plus tagged payload.
interface wt_mem_arbiter_if;
  import wt_cache_pkg::*;

  logic     valid;
  logic     ready;
  mem_req_t req;

  modport master (output valid, output req, input ready);
  modport slave  (input valid, input req, output ready);

endinterface

// File: rtl/wt_mem_tx_cnt.sv
// Per-source outstanding-transaction counter with saturating decrement
// and a sticky flag for returns that arrive with nothing outstanding.
module wt_mem_tx_cnt #(
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o,
  output logic err_o
);

  localparam logic [3:0] MaxCnt = 4'(MaxOutstanding);

  logic [3:0] r_cnt;
  logic       r_err;
  logic       w_dec_ok;

  assign w_dec_ok = dec_i && (r_cnt != 4'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= 4'd0;
      r_err <= 1'b0;
    end else begin
      if (inc_i && !w_dec_ok)      r_cnt <= r_cnt + 4'd1;
      else if (!inc_i && w_dec_ok) r_cnt <= r_cnt - 4'd1;
      if (dec_i && (r_cnt == 4'd0)) r_err <= 1'b1;
    end
  end

  assign full_o  = (r_cnt >= MaxCnt);
  assign empty_o = (r_cnt == 4'd0);
  assign err_o   = r_err;

endmodule

// File: rtl/wt_mem_arbiter.sv
// Round-robin I$/D$ arbiter into a single registered memory request slot,
// with per-source outstanding limits and same-cycle return routing.
module wt_mem_arbiter
  import wt_cache_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned TidWidth       = TID_W
) (
  input  logic          clk_i,
  input  logic          rst_i,

  input  logic          icache_req_i,
  output logic          icache_ack_o,
  input  mem_src_req_t  icache_data_i,

  input  logic          dcache_req_i,
  output logic          dcache_ack_o,
  input  mem_src_req_t  dcache_data_i,

  output logic          mem_valid_o,
  input  logic          mem_ready_i,
  output mem_req_t      mem_req_o,

  input  logic          mem_rtrn_vld_i,
  input  mem_rtrn_t     mem_rtrn_i,

  output logic          icache_rtrn_vld_o,
  output mem_src_rtrn_t icache_rtrn_o,
  output logic          dcache_rtrn_vld_o,
  output mem_src_rtrn_t dcache_rtrn_o,

  output logic          idle_o,
  output logic          err_o
);

  logic     r_vld;
  logic     r_last_d;
  mem_req_t r_req;

  logic w_i_full, w_i_empty, w_i_err;
  logic w_d_full, w_d_empty, w_d_err;
  logic w_i_elig, w_d_elig;
  logic w_cap_en;
  logic w_gnt_i, w_gnt_d;
  logic w_rtrn_src;
  logic w_i_rtrn, w_d_rtrn;

  // Capture is blocked during reset so an ack never pairs with a dropped request.
  assign w_cap_en = !rst_i && (!r_vld || mem_ready_i);
  assign w_i_elig = icache_req_i && !w_i_full;
  assign w_d_elig = dcache_req_i && !w_d_full;

  assign w_gnt_i = w_cap_en && w_i_elig && (!w_d_elig || r_last_d);
  assign w_gnt_d = w_cap_en && w_d_elig && (!w_i_elig || !r_last_d);

  assign icache_ack_o = w_gnt_i;
  assign dcache_ack_o = w_gnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld    <= 1'b0;
      r_last_d <= 1'b1;
    end else if (w_gnt_i || w_gnt_d) begin
      r_vld    <= 1'b1;
      r_last_d <= w_gnt_d;
    end else if (mem_ready_i) begin
      r_vld    <= 1'b0;
    end
  end

  // Payload needs no reset; it is only observed while r_vld is set.
  always_ff @(posedge clk_i) begin
    if (w_gnt_i)      r_req <= tag_req(icache_data_i, 1'b0);
    else if (w_gnt_d) r_req <= tag_req(dcache_data_i, 1'b1);
  end

  assign mem_valid_o = r_vld;
  assign mem_req_o   = r_req;

  assign w_rtrn_src = mem_rtrn_i.tid[TidWidth];
  assign w_i_rtrn   = mem_rtrn_vld_i && !rst_i && !w_rtrn_src;
  assign w_d_rtrn   = mem_rtrn_vld_i && !rst_i &&  w_rtrn_src;

  assign icache_rtrn_vld_o = w_i_rtrn;
  assign dcache_rtrn_vld_o = w_d_rtrn;
  assign icache_rtrn_o     = strip_rtrn(mem_rtrn_i);
  assign dcache_rtrn_o     = strip_rtrn(mem_rtrn_i);

  wt_mem_tx_cnt #(.MaxOutstanding(MaxOutstanding)) u_icnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (w_gnt_i),
    .dec_i   (w_i_rtrn),
    .full_o  (w_i_full),
    .empty_o (w_i_empty),
    .err_o   (w_i_err)
  );

  wt_mem_tx_cnt #(.MaxOutstanding(MaxOutstanding)) u_dcnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (w_gnt_d),
    .dec_i   (w_d_rtrn),
    .full_o  (w_d_full),
    .empty_o (w_d_empty),
    .err_o   (w_d_err)
  );

  assign idle_o = !r_vld && w_i_empty && w_d_empty;
  assign err_o  = w_i_err || w_d_err;

endmodule

// File: doc/wt_mem_arbiter.md
WT_MEM_ARBITER -- requirements
Module: wt_mem_arbiter

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 8, meaning the maximum in-flight transactions per source port (1..15).
REQ-002 SHALL have parameter TidWidth, default 2, meaning the width of the per-source transaction ID.
REQ-003 SHALL have clk_i, input, 1, the single clock.
REQ-004 SHALL have rst_i, input, 1, a synchronous, active-high reset.
REQ-005 SHALL have icache_req_i, input, 1, the I$ request, held until acked.
REQ-006 SHALL have icache_ack_o, output, 1, a one-cycle acceptance pulse for the I$ request.
REQ-007 SHALL have icache_data_i, input, mem_src_req_t, the I$ request payload {rtype, tid, paddr[63:0], size[2:0], data[63:0], nc}.
REQ-008 SHALL have dcache_req_i, dcache_ack_o and dcache_data_i, which are the same as REQ-005..007 for the D$.
REQ-009 SHALL have mem_valid_o, output, 1, and mem_ready_i, input, 1, forming the valid/ready handshake toward the memory adapter.
REQ-010 SHALL have mem_req_o, output, mem_req_t, which is the payload with tid widened to TidWidth+1 (MSB = source).
REQ-011 SHALL have mem_rtrn_vld_i, input, 1, and mem_rtrn_i, input, mem_rtrn_t {rtype, tid[TidWidth:0], data[127:0]}, carrying returns with no backpressure.
REQ-012 SHALL have icache_rtrn_vld_o/icache_rtrn_o and dcache_rtrn_vld_o/dcache_rtrn_o, output, 1/mem_src_rtrn_t, carrying routed returns with tid stripped to TidWidth.
REQ-013 SHALL have idle_o, output, 1, which is high when there are no outstanding transactions and the output register is empty.
REQ-014 SHALL have err_o, output, 1, a sticky error flag that sets on a return to a port with zero outstanding.

Function
REQ-015 SHALL hold the request in a single output register; mem_valid_o reflects register-full and mem_req_o is driven from the register only.
REQ-016 SHALL allow capture when the register is empty or (mem_valid_o && mem_ready_i), giving full throughput of one request per cycle.
REQ-017 SHALL treat a port as eligible when its req is high and its outstanding count is below MaxOutstanding, or equals MaxOutstanding-… no: only when below MaxOutstanding.
REQ-018 SHALL use round-robin arbitration: with both ports eligible, grant goes to the port not granted last; rr pointer resets to "last = dcache" so the I$ wins first.
REQ-019 SHALL pulse the winner's ack in the capture cycle; the loser's ack stays low; at most one ack per cycle.
REQ-020 SHALL set captured tid to {src, tid}, where src is 0 for I$ and 1 for D$; all other fields pass through unmodified.
REQ-021 SHALL increment the source counter on capture and decrement on a return whose tid MSB selects that source; simultaneous capture and return on the same port leaves it unchanged.
REQ-022 SHALL route a return combinationally in the same cycle: rtrn_vld_o for the selected port is high for exactly one cycle with mem_rtrn_i data.
REQ-023 SHALL ignore the counter decrement (saturate at 0) and set err_o for a return to a port with count 0; routing still occurs.
REQ-024 SHALL, when a port is at MaxOutstanding and a return frees a slot, make that port eligible in the next cycle (no same-cycle bypass).
REQ-025 SHALL hold mem_req_o stable while mem_valid_o && !mem_ready_i.

Reset
REQ-026 SHALL, on rst_i asserted at a clock edge, clear the register valid, both counters, err_o and the rr pointer; outputs then are mem_valid_o=0, acks=0, rtrn_vld_o=0 (absent input), idle_o=1, err_o=0.
REQ-027 SHALL drop any request in the output register on a mid-operation reset; returns arriving during reset are not routed.

Structure
REQ-028 SHALL place mem_src_req_t, mem_req_t, mem_rtrn_t, mem_src_rtrn_t and the rtype enum in wt_cache_pkg.
REQ-029 SHALL factor the per-port outstanding counter into sub-module wt_mem_tx_cnt (inc, dec, full, empty, err), instantiated twice.

Verification
REQ-030 SHALL verify simultaneous requests: icache_req_i=dcache_req_i=1 from reset with mem_ready_i=1 -> I$ acked cycle 1, D$ cycle 2, mem tids 0b0xx then 0b1xx.
REQ-031 SHALL verify stall: mem_ready_i=0 for 5 cycles after a capture -> mem_req_o constant, no further acks, mem_valid_o=1 throughout.
REQ-032 SHALL verify the outstanding limit: 8 D$ requests with no returns -> 9th not acked; a return with tid=0b101 -> ack the following cycle.
REQ-033 SHALL verify routing: mem_rtrn_vld_i with tid=0b010 -> icache_rtrn_vld_o=1 with tid=2 and dcache_rtrn_vld_o=0 in the same cycle.
REQ-034 SHALL verify spurious returns: a D$ return with D$ count 0 -> err_o=1 next cycle, stays 1 until rst_i.
REQ-035 SHALL verify reset mid-flight: rst_i with a full register and 3 outstanding -> next cycle mem_valid_o=0, idle_o=1.
